// File: rtl/ifetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/gnt/rvalid channel plus the
// valid/ready channel that hands fetched instructions to decode.
interface ifetch_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [WIDTH-1:0] imem_rdata;
  logic             instr_valid;
  logic             instr_ready;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] instr_pc;

  // Fetch stage side
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

  // Memory/decode side
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch around the external PC register: one outstanding imem request,
// redirect flush, registered decode handoff. Optional counters under IFETCH_PERF_EN.
module ifetch #(
  parameter int WIDTH = 32,
  parameter int INCR  = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] pc_next,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  ifetch_if.master         bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_stall
`endif
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HOLD} state_t;

  localparam logic [WIDTH-1:0] INCR_W     = WIDTH'(INCR);
  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

  state_t           state;
  logic             valid_q;
  logic [WIDTH-1:0] instr_q;
  logic [WIDTH-1:0] pc_q;

  assign bus.imem_req    = nrst && (state == REQ);
  assign bus.imem_addr   = pc_in;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = pc_q;

  // Redirect wins over the sequential advance; reset forces a hold.
  always_comb begin
    pc_next = pc_in;
    if (nrst) begin
      if (redirect)
        pc_next = redirect_target & ALIGN_MASK;
      else if (state == WAIT && bus.imem_rvalid)
        pc_next = pc_in + INCR_W;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      case (state)
        IDLE: if (!redirect) state <= REQ;
        REQ: begin
          if (redirect)
            state <= bus.imem_gnt ? DROP : IDLE;
          else if (bus.imem_gnt)
            state <= WAIT;
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            if (redirect) begin
              state <= IDLE;
            end else begin
              state   <= HOLD;
              valid_q <= 1'b1;
              instr_q <= bus.imem_rdata;
              pc_q    <= pc_in;
            end
          end else if (redirect) begin
            state <= DROP;
          end
        end
        // Granted request whose response must be swallowed before refetching.
        DROP: if (bus.imem_rvalid) state <= IDLE;
        HOLD: begin
          if (redirect) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end else if (bus.instr_ready) begin
            state   <= REQ;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!nrst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (state == WAIT && bus.imem_rvalid && !redirect)
        perf_fetched <= perf_fetched + 32'd1;
      if ((state == REQ && !bus.imem_gnt) ||
          ((state == WAIT || state == DROP) && !bus.imem_rvalid))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: bench-owned PC register, scoreboard of expected
// (instr, pc) pairs popped on each decode handshake.
module tb_ifetch;
  logic        clk;
  logic        nrst;
  logic [31:0] pc_in;
  logic [31:0] pc_next;
  logic        redirect;
  logic [31:0] redirect_target;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb[$];

  ifetch_if #(.WIDTH(32)) bus ();

  ifetch #(.WIDTH(32), .INCR(4)) dut (
    .clk             (clk),
    .nrst            (nrst),
    .pc_in           (pc_in),
    .pc_next         (pc_next),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .bus             (bus)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_stall      (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) pc_in <= nrst ? pc_next : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Settle inputs, score any decode handshake in this cycle, then advance one edge.
  task automatic cyc();
    logic [63:0] e;
    #1;
    if (nrst && bus.instr_valid && bus.instr_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb_unexpected observed=%h expected=none", bus.instr);
      end else begin
        e = sb.pop_front();
        chk("sb_instr", bus.instr, e[63:32]);
        chk("sb_pc", bus.instr_pc, e[31:0]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    nrst = 1'b0; redirect = 1'b1; redirect_target = 32'h50;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
    cyc(); cyc();
    #1;
    chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
    chk("rst_pc_next_hold", pc_next, 32'h0);
    chk("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);

    // First fetch: gnt with req, rvalid the next cycle.
    redirect = 1'b0; nrst = 1'b1; bus.imem_gnt = 1'b1;
    #1 chk("idle_req", {31'b0, bus.imem_req}, 32'h0);
    cyc();
    chk("req_asserted", {31'b0, bus.imem_req}, 32'h1);
    chk("req_addr0", bus.imem_addr, 32'h0);
    cyc();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h13;
    sb.push_back({32'h13, pc_in});
    #1;
    chk("wait_pc_next", pc_next, 32'h4);
    chk("wait_req_low", {31'b0, bus.imem_req}, 32'h0);
    cyc();
    bus.imem_rvalid = 1'b0;
    chk("cap_valid", {31'b0, bus.instr_valid}, 32'h1);
    chk("cap_instr", bus.instr, 32'h13);
    chk("cap_pc", bus.instr_pc, 32'h0);
    chk("pc_adv", pc_in, 32'h4);

    // Decode back-pressure for five cycles.
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("hold_valid", {31'b0, bus.instr_valid}, 32'h1);
      chk("hold_instr", bus.instr, 32'h13);
      chk("hold_pc", bus.instr_pc, 32'h0);
      chk("hold_req", {31'b0, bus.imem_req}, 32'h0);
      chk("hold_pc_next", pc_next, 32'h4);
    end
    bus.instr_ready = 1'b1;
    cyc();
    chk("rereq", {31'b0, bus.imem_req}, 32'h1);
    chk("rereq_addr", bus.imem_addr, 32'h4);

    // Grant withheld for three cycles.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_req", {31'b0, bus.imem_req}, 32'h1);
      chk("stall_addr", bus.imem_addr, 32'h4);
    end
    bus.imem_gnt = 1'b1;
    cyc();
    bus.imem_gnt = 1'b0;
`ifdef IFETCH_PERF_EN
    chk("perf_stall_3", perf_stall, 32'd3);
`endif

    // Redirect while waiting: the in-flight response is discarded.
    redirect = 1'b1; redirect_target = 32'h103;
    #1 chk("redir_pc_next", pc_next, 32'h100);
    cyc();
    redirect = 1'b0;
    cyc();
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD;
    cyc();
    bus.imem_rvalid = 1'b0;
    chk("drop_no_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("drop_pc", pc_in, 32'h100);
`ifdef IFETCH_PERF_EN
    chk("perf_stall_5", perf_stall, 32'd5);
`endif
    cyc();
    chk("redir_req", {31'b0, bus.imem_req}, 32'h1);
    chk("redir_addr", bus.imem_addr, 32'h100);

    // Redirect coinciding with rvalid: no capture.
    bus.imem_gnt = 1'b1;
    cyc();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD;
    redirect = 1'b1; redirect_target = 32'h200;
    cyc();
    redirect = 1'b0; bus.imem_rvalid = 1'b0;
    chk("rv_redir_no_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("rv_redir_pc", pc_in, 32'h200);
    cyc();
    chk("rv_redir_addr", bus.imem_addr, 32'h200);
    bus.imem_gnt = 1'b1;
    cyc();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h11;
    sb.push_back({32'h11, pc_in});
    cyc();
    bus.imem_rvalid = 1'b0;
    chk("cap2_instr", bus.instr, 32'h11);

    // Redirect in HOLD with ready high: the handshake completes, valid drops.
    redirect = 1'b1; redirect_target = 32'h300;
    cyc();
    redirect = 1'b0;
    chk("hold_redir_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("hold_redir_pc", pc_in, 32'h300);
    cyc();
    chk("hold_redir_addr", bus.imem_addr, 32'h300);

    // Top-of-address-space wrap.
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFF;
    #1 chk("wrap_target_align", pc_next, 32'hFFFF_FFFC);
    cyc();
    redirect = 1'b0;
    cyc();
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    bus.imem_gnt = 1'b1;
    cyc();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hAB;
    sb.push_back({32'hAB, pc_in});
    #1 chk("wrap_pc_next", pc_next, 32'h0);
    cyc();
    bus.imem_rvalid = 1'b0;
    chk("wrap_instr_pc", bus.instr_pc, 32'hFFFF_FFFC);
    cyc();
    chk("wrap_rereq", {31'b0, bus.imem_req}, 32'h1);
`ifdef IFETCH_PERF_EN
    chk("perf_stall_6", perf_stall, 32'd6);
    chk("perf_fetched_3", perf_fetched, 32'd3);
`endif

    // Reset asserted in WAIT.
    bus.imem_gnt = 1'b1;
    cyc();
    bus.imem_gnt = 1'b0; nrst = 1'b0; redirect = 1'b1; redirect_target = 32'h40;
    #1;
    chk("mid_rst_req", {31'b0, bus.imem_req}, 32'h0);
    chk("mid_rst_pc_next", pc_next, pc_in);
    cyc();
    chk("mid_rst_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("mid_rst_instr", bus.instr, 32'h0);
`ifdef IFETCH_PERF_EN
    chk("mid_rst_perf", perf_fetched | perf_stall, 32'h0);
`endif
    nrst = 1'b1; redirect = 1'b0;
    #1 chk("post_rst_idle", {31'b0, bus.imem_req}, 32'h0);
    cyc();
    chk("post_rst_req", {31'b0, bus.imem_req}, 32'h1);
    chk("post_rst_addr", bus.imem_addr, 32'h0);
    chk("sb_drained", sb.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
